// File: rtl/jkff_arb_pkg.sv
// jkff_arb_pkg: shared types and constants for the JK bank arbiter
// Contents: op_e ({j,k} operation), state_e (arbiter FSM), TOGGLE_CNT_W
package jkff_arb_pkg;

    localparam int TOGGLE_CNT_W = 16;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

endpackage

// File: rtl/jkff_cell.sv
// jkff_cell: single JK flip-flop with synchronous active-high reset
// Ports: clk, rst (sync, active high), j, k (JK inputs), q (stored bit)
module jkff_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q, q_d;

    always_comb q_d = (j && k) ? ~q_q : j ? 1'b1 : k ? 1'b0 : q_q;

    always_ff @(posedge clk)
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;

    assign q = q_q;

endmodule

// File: rtl/jkff_bank_arbiter.sv
// jkff_bank_arbiter: round-robin sharing of a bank of N JK cells between two requesters
// Ports: clk, rst (sync, active high); reqX_valid/idx/op in, reqX_ready out (X = 0,1);
//        q (bank state), busy (command being applied), cmd_drop (applied idx >= N),
//        toggle_cnt (applied toggles, only counted when JKFF_ARB_TOGGLE_CNT_EN is defined)
module jkff_bank_arbiter
    import jkff_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic [W-1:0]            req0_idx,
    input  logic [1:0]              req0_op,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [W-1:0]            req1_idx,
    input  logic [1:0]              req1_op,
    output logic                    req1_ready,
    output logic [N-1:0]            q,
    output logic                    busy,
    output logic                    cmd_drop,
    output logic [TOGGLE_CNT_W-1:0] toggle_cnt
);

    state_e         state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    op_e            op_q, op_d;
    logic           who_q, who_d;
    logic           lrg_q, lrg_d;
    logic           grant0, grant1, hs0, hs1, in_range, apply;
    logic [N-1:0]   j_vec, k_vec;

    // On a tie the requester that was not served last wins
    assign grant0     = req0_valid && (!req1_valid || lrg_q);
    assign grant1     = req1_valid && (!req0_valid || !lrg_q);
    assign req0_ready = !rst && state_q == ST_IDLE && grant0;
    assign req1_ready = !rst && state_q == ST_IDLE && grant1;
    assign hs0        = req0_valid && req0_ready;
    assign hs1        = req1_valid && req1_ready;

    // Indices past the bank end are only reachable when N is not a power of two
    assign in_range = 32'(idx_q) < N;
    assign apply    = state_q == ST_APPLY && in_range;
    assign busy     = state_q == ST_APPLY;
    assign cmd_drop = busy && !in_range && !rst;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        who_d   = who_q;
        lrg_d   = lrg_q;
        if (state_q == ST_IDLE && (hs0 || hs1)) begin
            state_d = ST_APPLY;
            idx_d   = hs1 ? req1_idx : req0_idx;
            op_d    = op_e'(hs1 ? req1_op : req0_op);
            who_d   = hs1;
        end else if (state_q == ST_APPLY) begin
            state_d = ST_IDLE;
            lrg_d   = who_q;
        end
    end

    // Only the addressed cell sees the latched j/k; the rest hold
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        for (int i = 0; i < N; i++) begin
            j_vec[i] = apply && idx_q == W'(i) && op_q[1];
            k_vec[i] = apply && idx_q == W'(i) && op_q[0];
        end
    end

    always_ff @(posedge clk)
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= OP_HOLD;
            who_q   <= 1'b0;
            lrg_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            who_q   <= who_d;
            lrg_q   <= lrg_d;
        end

    for (genvar g = 0; g < N; g++) begin : g_cell
        jkff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_vec[g]),
            .k   (k_vec[g]),
            .q   (q[g])
        );
    end

`ifdef JKFF_ARB_TOGGLE_CNT_EN
    logic [TOGGLE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (apply && op_q == OP_TGL && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign toggle_cnt = cnt_q;
`else
    assign toggle_cnt = '0;
`endif

endmodule
